// File: rtl/game_matrix_memory.sv
// Tetris-style playfield: occupancy register array with a combinational 4x4 collision
// window, tile merge on lock, and bottom-up full-row detection and removal.
package game_matrix_pkg;
  typedef struct packed {
    logic signed [7:0] x_m;
    logic signed [7:0] y_m;
  } point_t;

  typedef logic [3:0][3:0] shape_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;
endpackage

module game_matrix_memory
  import game_matrix_pkg::*;
#(
  parameter int width_p  = 10,
  parameter int height_p = 20
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        empty_i,
  input  point_t                      mm_addr_i,
  output logic [3:0][3:0]             mm_data_o,
  input  logic                        lock_v_i,
  input  point_t                      lock_pos_i,
  input  shape_t                      lock_shape_i,
  output logic                        ready_o,
  output logic                        done_o,
  output logic [2:0]                  lines_cleared_o,
  output logic                        overflow_o,
  input  logic [$clog2(height_p)-1:0] disp_row_i,
  output logic [width_p-1:0]          disp_row_o
);

  localparam int row_w_lp = $clog2(height_p);
  localparam int col_w_lp = $clog2(width_p);

  typedef logic [height_p-1:0][width_p-1:0] board_t;

  state_e              state_q, state_d;
  board_t              board_q, board_d;
  logic [row_w_lp-1:0] row_q, row_d;
  logic [2:0]          count_q, count_d;
  logic [2:0]          lines_q, lines_d;
  logic                overflow_q, overflow_d;
  logic [2:0]          count_inc;

  // Walls and floor read as occupied so tiles collide with them; space above the top is free.
  function automatic logic window_cell(input board_t b, input int row, input int col);
    if (col < 0 || col >= width_p || row >= height_p) return 1'b1;
    if (row < 0) return 1'b0;
    return b[row[row_w_lp-1:0]][col[col_w_lp-1:0]];
  endfunction

  function automatic board_t merge_shape(input board_t b, input point_t p, input shape_t s);
    board_t m = b;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        int row = int'(p.y_m) + r;
        int col = int'(p.x_m) + c;
        if (s[r][c] && row >= 0 && row < height_p && col >= 0 && col < width_p)
          m[row[row_w_lp-1:0]][col[col_w_lp-1:0]] = 1'b1;
      end
    end
    return m;
  endfunction

  function automatic logic above_top(input point_t p, input shape_t s);
    logic hit = 1'b0;
    for (int r = 0; r < 4; r++) begin
      if ((int'(p.y_m) + r) < 0 && (s[r] != 4'b0000)) hit = 1'b1;
    end
    return hit;
  endfunction

  always_comb begin
    mm_data_o = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        mm_data_o[r][c] = window_cell(board_q, int'(mm_addr_i.y_m) + r, int'(mm_addr_i.x_m) + c);
      end
    end
  end

  assign disp_row_o = (int'(disp_row_i) < height_p) ? board_q[disp_row_i] : '0;

  assign count_inc = (count_q == 3'd4) ? 3'd4 : count_q + 3'd1;

  // State register; board reset is required here since empty_i must clear it in one cycle.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    if (reset_i || empty_i) begin
      state_q    <= IDLE;
      board_q    <= '0;
      row_q      <= '0;
      count_q    <= '0;
      lines_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      board_q    <= board_d;
      row_q      <= row_d;
      count_q    <= count_d;
      lines_q    <= lines_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through the case leaves a target unassigned (no latch).
    state_d    = state_q;
    board_d    = board_q;
    row_d      = row_q;
    count_d    = count_q;
    lines_d    = lines_q;
    overflow_d = overflow_q;
    unique case (state_q)
      IDLE: begin
        if (lock_v_i) begin
          board_d = merge_shape(board_q, lock_pos_i, lock_shape_i);
          if (above_top(lock_pos_i, lock_shape_i)) overflow_d = 1'b1;
          row_d   = row_w_lp'(height_p - 1);
          count_d = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (&board_q[row_q]) begin
          state_d = SHIFT;
        end else if (row_q == '0) begin
          lines_d = count_q;
          state_d = DONE;
        end else begin
          row_d = row_q - row_w_lp'(1);
        end
      end
      SHIFT: begin
        for (int i = 1; i < height_p; i++) begin
          if (i <= int'(row_q)) board_d[i] = board_q[i-1];
        end
        board_d[0] = '0;
        count_d    = count_inc;
        // The row dropping into row_r is checked here, in the same cycle as the shift,
        // so each cleared row costs exactly one extra cycle.
        if (row_q != '0 && (&board_q[row_q - row_w_lp'(1)])) begin
          state_d = SHIFT;
        end else if (row_q == '0) begin
          lines_d = count_inc;
          state_d = DONE;
        end else begin
          row_d   = row_q - row_w_lp'(1);
          state_d = SCAN;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready_o         = (state_q == IDLE);
    done_o          = (state_q == DONE);
    lines_cleared_o = lines_q;
    overflow_o      = overflow_q;
  end

endmodule

// File: tb/tb_game_matrix_memory.sv
// Directed bench for game_matrix_memory: window edges, merge, line clears, overflow,
// ignored locks and synchronous clears, with hand-computed expectations.
module tb_game_matrix_memory;
  import game_matrix_pkg::*;

  logic            clk_i = 1'b0;
  logic            reset_i, empty_i, lock_v_i;
  point_t          mm_addr_i, lock_pos_i;
  logic [3:0][3:0] mm_data_o;
  shape_t          lock_shape_i;
  logic            ready_o, done_o, overflow_o;
  logic [2:0]      lines_cleared_o;
  logic [4:0]      disp_row_i;
  logic [9:0]      disp_row_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_i = ~clk_i;

  game_matrix_memory dut (
    .clk_i(clk_i), .reset_i(reset_i), .empty_i(empty_i),
    .mm_addr_i(mm_addr_i), .mm_data_o(mm_data_o),
    .lock_v_i(lock_v_i), .lock_pos_i(lock_pos_i), .lock_shape_i(lock_shape_i),
    .ready_o(ready_o), .done_o(done_o), .lines_cleared_o(lines_cleared_o),
    .overflow_o(overflow_o), .disp_row_i(disp_row_i), .disp_row_o(disp_row_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic read_row(input int r, output logic [9:0] v);
    disp_row_i = 5'(r);
    #1;
    v = disp_row_o;
  endtask

  task automatic board_or(output logic [9:0] acc);
    logic [9:0] v;
    acc = '0;
    for (int i = 0; i < 20; i++) begin
      read_row(i, v);
      acc |= v;
    end
  endtask

  task automatic window(input int x, input int y, output logic [15:0] v);
    mm_addr_i.x_m = 8'(x);
    mm_addr_i.y_m = 8'(y);
    #1;
    v = mm_data_o;
  endtask

  task automatic lock_wait(input int x, input int y, input logic [15:0] shp,
                           output int lat, output logic [2:0] lc);
    @(negedge clk_i);
    lock_v_i        = 1'b1;
    lock_pos_i.x_m  = 8'(x);
    lock_pos_i.y_m  = 8'(y);
    lock_shape_i    = shp;
    @(negedge clk_i);
    lock_v_i = 1'b0;
    lat = 1;
    while (!done_o && lat < 200) begin
      @(negedge clk_i);
      lat++;
    end
    if (!done_o) check("done_timeout", 32'd0, 32'd1);
    lc = lines_cleared_o;
  endtask

  task automatic pulse_clear(input logic use_reset);
    @(negedge clk_i);
    if (use_reset) reset_i = 1'b1; else empty_i = 1'b1;
    @(negedge clk_i);
    reset_i = 1'b0;
    empty_i = 1'b0;
  endtask

  task automatic count_done(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk_i);
      if (done_o) n++;
    end
  endtask

  initial begin
    logic [9:0]  v;
    logic [15:0] w;
    logic [2:0]  lc;
    int          lat, nd;

    reset_i = 1'b1; empty_i = 1'b0; lock_v_i = 1'b0;
    mm_addr_i = '0; lock_pos_i = '0; lock_shape_i = '0; disp_row_i = '0;
    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;

    // Reset state
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_lines", 32'(lines_cleared_o), 32'd0);
    check("rst_ovf", 32'(overflow_o), 32'd0);
    board_or(v);
    check("rst_board", 32'(v), 32'd0);

    // Window boundaries on an empty board
    window(-1, 0, w);  check("win_left_wall", 32'(w), 32'h1111);
    window(0, 18, w);  check("win_floor", 32'(w), 32'hFF00);
    window(0, -2, w);  check("win_above_top", 32'(w), 32'h0000);
    window(8, 0, w);   check("win_right_wall", 32'(w), 32'hCCCC);

    // Single line clear
    lock_wait(0, 18, 16'h00F1, lat, lc);
    check("l1_latency", 32'(lat), 32'd21);
    check("l1_lines", 32'(lc), 32'd0);
    read_row(19, v); check("l1_row19", 32'(v), 32'h00F);
    read_row(18, v); check("l1_row18", 32'(v), 32'h001);
    lock_wait(4, 19, 16'h0003, lat, lc);
    read_row(19, v); check("l2_row19", 32'(v), 32'h03F);
    lock_wait(6, 19, 16'h000F, lat, lc);
    check("clr1_latency", 32'(lat), 32'd22);
    check("clr1_lines", 32'(lc), 32'd1);
    read_row(19, v); check("clr1_row19", 32'(v), 32'h001);
    read_row(18, v); check("clr1_row18", 32'(v), 32'h000);
    @(negedge clk_i);
    check("clr1_lines_hold", 32'(lines_cleared_o), 32'd1);
    check("clr1_ready_after", 32'(ready_o), 32'd1);
    window(0, 16, w);  check("clr1_window", 32'(w), 32'h1000);

    // empty_i clears board and result
    pulse_clear(1'b0);
    board_or(v);
    check("empty_board", 32'(v), 32'd0);
    check("empty_lines", 32'(lines_cleared_o), 32'd0);

    // Four-line clear
    lock_wait(0, 16, 16'hFFFF, lat, lc);
    lock_wait(4, 16, 16'hFFFF, lat, lc);
    lock_wait(8, 16, 16'h1111, lat, lc);
    check("pre4_lines", 32'(lc), 32'd0);
    read_row(17, v); check("pre4_row17", 32'(v), 32'h1FF);
    lock_wait(9, 16, 16'h1111, lat, lc);
    check("clr4_latency", 32'(lat), 32'd25);
    check("clr4_lines", 32'(lc), 32'd4);
    board_or(v);
    check("clr4_board", 32'(v), 32'd0);

    // Overflow above the top edge
    pulse_clear(1'b1);
    check("ovf_before", 32'(overflow_o), 32'd0);
    lock_wait(0, -1, 16'h0011, lat, lc);
    check("ovf_set", 32'(overflow_o), 32'd1);
    read_row(0, v); check("ovf_merged_row0", 32'(v), 32'h001);
    window(0, -1, w);  check("ovf_window", 32'(w), 32'h0010);
    lock_wait(5, 19, 16'h0001, lat, lc);
    check("ovf_sticky", 32'(overflow_o), 32'd1);
    pulse_clear(1'b0);
    check("ovf_cleared", 32'(overflow_o), 32'd0);

    // Lock request during SCAN is ignored
    pulse_clear(1'b1);
    @(negedge clk_i);
    lock_v_i = 1'b1; lock_pos_i.x_m = 8'sd0; lock_pos_i.y_m = 8'sd19; lock_shape_i = 16'h000F;
    @(negedge clk_i);
    lock_v_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check("busy_ready", 32'(ready_o), 32'd0);
    lock_v_i = 1'b1; lock_pos_i.x_m = 8'sd4; lock_shape_i = 16'h000F;
    @(negedge clk_i);
    lock_v_i = 1'b0;
    count_done(40, nd);
    check("busy_done_count", 32'(nd), 32'd1);
    read_row(19, v); check("busy_row19", 32'(v), 32'h00F);

    // empty_i during SHIFT aborts
    pulse_clear(1'b1);
    lock_wait(0, 19, 16'h000F, lat, lc);
    lock_wait(4, 19, 16'h0003, lat, lc);
    @(negedge clk_i);
    lock_v_i = 1'b1; lock_pos_i.x_m = 8'sd6; lock_pos_i.y_m = 8'sd19; lock_shape_i = 16'h000F;
    @(negedge clk_i);
    lock_v_i = 1'b0;
    @(negedge clk_i);
    check("shift_ready", 32'(ready_o), 32'd0);
    read_row(19, v); check("shift_row19_full", 32'(v), 32'h3FF);
    empty_i = 1'b1;
    @(negedge clk_i);
    empty_i = 1'b0;
    check("abort_ready", 32'(ready_o), 32'd1);
    check("abort_done", 32'(done_o), 32'd0);
    board_or(v);
    check("abort_board", 32'(v), 32'd0);
    count_done(30, nd);
    check("abort_no_done", 32'(nd), 32'd0);

    // reset_i wins over lock_v_i in the same cycle
    @(negedge clk_i);
    reset_i = 1'b1;
    lock_v_i = 1'b1; lock_pos_i.x_m = 8'sd0; lock_pos_i.y_m = 8'sd19; lock_shape_i = 16'h000F;
    @(negedge clk_i);
    reset_i = 1'b0;
    lock_v_i = 1'b0;
    check("prio_ready", 32'(ready_o), 32'd1);
    read_row(19, v); check("prio_row19", 32'(v), 32'h000);
    count_done(30, nd);
    check("prio_no_done", 32'(nd), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
